// File: rtl/pmem_arbiter_n.sv
// Purpose: N-port arbiter onto one line-wide pmem port, fixed-priority or round-robin, with optional read merging.
// Latency: request in IDLE at t -> GRANT t+1 -> strobe from t+2 -> resp pulse the cycle after pmem_resp.
// Backpressure: one transaction outstanding; requesters hold req_* until their resp pulse, pmem_resp ends the access.
module pmem_arbiter_n #(
    parameter int NUM_PORTS   = 2,
    parameter int LINE_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int ARB_MODE    = 0,
    parameter int MERGE_READS = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata,
    input  logic                             pmem_resp,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata
);

    localparam int OFS = $clog2(LINE_WIDTH / 8);
    localparam int IW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, FINISH} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [NUM_PORTS-1:0]    requesting;
    logic [IW-1:0]           last_grant;
    logic [IW-1:0]           winner_q;
    logic [IW-1:0]           winner_c;
    logic                    winner_vld;
    logic                    op_write_q;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [LINE_WIDTH-1:0]   sel_wdata;
    logic                    sel_write;
    logic [NUM_PORTS-1:0]    merge_hit;

    assign requesting = req_read | req_write;

    // Winner search: later loop iterations overwrite earlier ones, so the
    // highest-priority candidate is visited last.
    always_comb begin
        winner_c   = '0;
        winner_vld = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (requesting[i]) begin
                    winner_c   = IW'(i);
                    winner_vld = 1'b1;
                end
            end
        end else begin
            // Distance k=1 from last_grant is the most preferred, so walk k downward.
            for (int k = NUM_PORTS; k >= 1; k--) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if ((i == ((int'(last_grant) + k) % NUM_PORTS)) && requesting[i]) begin
                        winner_c   = IW'(i);
                        winner_vld = 1'b1;
                    end
                end
            end
        end
    end

    // Mux the winner's address, write line and op type; a write on the port wins over its read.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (winner_c == IW'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
                sel_write = req_write[i];
            end
        end
    end

    // Pure readers of the latched line; ports that also assert write are excluded.
    always_comb begin
        merge_hit = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            merge_hit[j] = req_read[j] && !req_write[j] &&
                (req_addr[j*ADDR_WIDTH+OFS +: ADDR_WIDTH-OFS] == pmem_address[ADDR_WIDTH-1:OFS]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; GRANT falls back to IDLE if the requester vanished.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|requesting) state_nxt = GRANT;
            GRANT:   state_nxt = winner_vld ? ACCESS : IDLE;
            ACCESS:  if (pmem_resp) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: strobes during ACCESS, completion pulses during FINISH.
    always_comb begin
        pmem_read  = (state == ACCESS) && !op_write_q;
        pmem_write = (state == ACCESS) &&  op_write_q;
        req_resp   = '0;
        if (state == FINISH) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_resp[i] = (winner_q == IW'(i));
            end
            if ((MERGE_READS != 0) && !op_write_q) begin
                req_resp = req_resp | merge_hit;
            end
        end
    end

    // Transaction latch at GRANT and read-line capture at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= IW'(NUM_PORTS - 1);
            winner_q     <= '0;
            op_write_q   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            req_rdata    <= '0;
        end else begin
            if ((state == GRANT) && winner_vld) begin
                winner_q     <= winner_c;
                last_grant   <= winner_c;
                op_write_q   <= sel_write;
                pmem_address <= {sel_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                if (sel_write) begin
                    pmem_wdata <= sel_wdata;
                end
            end
            if ((state == ACCESS) && pmem_resp && !op_write_q) begin
                req_rdata <= pmem_rdata;
            end
        end
    end

endmodule
